des_job_controller: RTL and testbench

Initiator side of the per-core start/restart/done handshake used by the linear-cryptanalysis DES cores.
- Takes one job request (base seed, seed stride, batch count) from the AXI register bank.
- Assigns a distinct non-zero LFSR seed to each core and launches all cores in lock-step.
- Waits for every core's done, sums the per-core 64-bit bias counters into one saturating total, then restarts the cores for the next batch until the job completes.

---
 rtl/des_job_controller.sv | 176 +++++++++++++++++
 tb/tb_des_job_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_job_controller.sv
// Job initiator for the linear-cryptanalysis DES core array: seeds and launches
// all cores in lock-step, gathers their bias counters into a saturating total.

module des_seed_lane #(
  parameter int IDX = 0
) (
  input  logic [63:0] base,
  input  logic [63:0] stride,
  output logic [63:0] seed
);
  logic [63:0] raw;
  assign raw  = base + 64'(IDX) * stride;
  // An all-zero seed would lock the core's LFSR.
  assign seed = (raw == '0) ? 64'h1 : raw;
endmodule

module des_job_controller #(
  parameter int NUM_CORES = 6,
  parameter int CNT_W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_start,
  input  logic                       job_abort,
  input  logic [63:0]                seed_base,
  input  logic [63:0]                seed_stride,
  input  logic [31:0]                job_batches,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES*CNT_W-1:0] core_counter,
  output logic [NUM_CORES-1:0]       core_start,
  output logic                       core_restart,
  output logic [NUM_CORES*64-1:0]    core_seed,
  output logic [CNT_W-1:0]           total_counter,
  output logic [31:0]                batches_done,
  output logic                       busy,
  output logic                       job_done,
  output logic                       saturated
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_COLLECT, S_RESTART, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [63:0]                   stride_q, stride_d;
  logic [31:0]                   batches_q, batches_d;
  logic [63:0]                   next_seed_q, next_seed_d;
  logic [NUM_CORES-1:0][63:0]    core_seed_q, core_seed_d;
  logic [CNT_W-1:0]              total_q, total_d;
  logic [31:0]                   batches_done_q, batches_done_d;
  logic                          sat_q, sat_d;
  logic [NUM_CORES-1:0]          done_seen_q, done_seen_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          abort_q, abort_d;

  logic [NUM_CORES-1:0][63:0]    lane_seed;
  logic [NUM_CORES-1:0][CNT_W-1:0] cnt_arr;
  logic [CNT_W:0]                sum;

  assign cnt_arr = core_counter;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    des_seed_lane #(.IDX(i)) u_lane (
      .base   (next_seed_q),
      .stride (stride_q),
      .seed   (lane_seed[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      stride_q       <= '0;
      batches_q      <= '0;
      next_seed_q    <= '0;
      core_seed_q    <= '0;
      total_q        <= '0;
      batches_done_q <= '0;
      sat_q          <= 1'b0;
      done_seen_q    <= '0;
      idx_q          <= '0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      stride_q       <= stride_d;
      batches_q      <= batches_d;
      next_seed_q    <= next_seed_d;
      core_seed_q    <= core_seed_d;
      total_q        <= total_d;
      batches_done_q <= batches_done_d;
      sat_q          <= sat_d;
      done_seen_q    <= done_seen_d;
      idx_q          <= idx_d;
      abort_q        <= abort_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    stride_d       = stride_q;
    batches_d      = batches_q;
    next_seed_d    = next_seed_q;
    core_seed_d    = core_seed_q;
    total_d        = total_q;
    batches_done_d = batches_done_q;
    sat_d          = sat_q;
    done_seen_d    = done_seen_q;
    idx_d          = idx_q;
    abort_d        = 1'b0;
    sum            = '0;

    case (state_q)
      S_IDLE: begin
        if (job_start && !job_abort) begin
          stride_d       = seed_stride;
          batches_d      = job_batches;
          next_seed_d    = seed_base;
          total_d        = '0;
          batches_done_d = '0;
          sat_d          = 1'b0;
          state_d        = (job_batches == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        core_seed_d = lane_seed;
        next_seed_d = next_seed_q + 64'(NUM_CORES) * stride_q;
        state_d     = S_START;
      end
      S_START: begin
        done_seen_d = '0;
        idx_d       = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        done_seen_d = done_seen_q | core_done;
        if (&done_seen_d) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        sum     = {1'b0, total_q} + {1'b0, cnt_arr[idx_q]};
        total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        sat_d   = sat_q | sum[CNT_W];
        if (idx_q == LAST_IDX) begin
          batches_done_d = batches_done_q + 32'd1;
          state_d = (batches_done_d == batches_q) ? S_DONE : S_RESTART;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_RESTART: state_d = S_LOAD;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort freezes the partial results and pulses restart on the way out.
    if (job_abort && state_q != S_IDLE) begin
      state_d        = S_IDLE;
      abort_d        = 1'b1;
      next_seed_d    = next_seed_q;
      core_seed_d    = core_seed_q;
      total_d        = total_q;
      batches_done_d = batches_done_q;
      sat_d          = sat_q;
    end
  end

  assign core_start    = {NUM_CORES{state_q == S_START}};
  assign core_restart  = (state_q == S_RESTART) | abort_q;
  assign core_seed     = core_seed_q;
  assign total_counter = total_q;
  assign batches_done  = batches_done_q;
  assign busy          = (state_q != S_IDLE);
  assign job_done      = (state_q == S_DONE);
  assign saturated     = sat_q;
endmodule

// File: tb/tb_des_job_controller.sv
// Scoreboard bench for des_job_controller with a simple delay-programmable core model.

module tb_des_job_controller;
  localparam int NC = 6;
  localparam int CW = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              job_start = 1'b0;
  logic              job_abort = 1'b0;
  logic [63:0]       seed_base = '0;
  logic [63:0]       seed_stride = '0;
  logic [31:0]       job_batches = '0;
  logic [NC-1:0]     core_done = '0;
  logic [NC*CW-1:0]  core_counter;
  logic [NC-1:0]     core_start;
  logic              core_restart;
  logic [NC*64-1:0]  core_seed;
  logic [CW-1:0]     total_counter;
  logic [31:0]       batches_done;
  logic              busy;
  logic              job_done;
  logic              saturated;

  des_job_controller #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_start     (job_start),
    .job_abort     (job_abort),
    .seed_base     (seed_base),
    .seed_stride   (seed_stride),
    .job_batches   (job_batches),
    .core_done     (core_done),
    .core_counter  (core_counter),
    .core_start    (core_start),
    .core_restart  (core_restart),
    .core_seed     (core_seed),
    .total_counter (total_counter),
    .batches_done  (batches_done),
    .busy          (busy),
    .job_done      (job_done),
    .saturated     (saturated)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_start = 0, n_restart = 0, n_done = 0;
  int last_start_cyc = 0, last_done_cyc = 0, done_cyc = 0, t_start = 0;

  logic [63:0] exp_seed_q[$];
  logic [63:0] exp_tot_q[$];
  logic [63:0] exp_bd_q[$];
  logic        exp_sat_q[$];

  logic [63:0] cnt_val[NC];
  int          dly[NC];
  int          timer[NC];
  bit          pulse_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    for (int i = 0; i < NC; i++) core_counter[i*CW +: CW] = cnt_val[i];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core model: done rises dly[i] cycles after start; pulse or level until next start.
  always @(negedge clk) begin
    if (!rst_n) begin
      core_done = '0;
      for (int i = 0; i < NC; i++) timer[i] = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          timer[i] = dly[i];
          core_done[i] = 1'b0;
        end else if (timer[i] > 0) begin
          timer[i] = timer[i] - 1;
          if (timer[i] == 0) begin
            core_done[i] = 1'b1;
            last_done_cyc = cyc;
          end
        end else if (pulse_mode) begin
          core_done[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches cores or finishes a job.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|core_start) begin
        chk("start_all", 64'(core_start), 64'h3F);
        n_start++;
        last_start_cyc = cyc;
        chk("seed_sb_avail", 64'(exp_seed_q.size() >= NC), 64'd1);
        for (int i = 0; i < NC; i++)
          if (exp_seed_q.size() > 0)
            chk($sformatf("seed%0d", i), core_seed[i*64 +: 64], exp_seed_q.pop_front());
      end
      if (core_restart) n_restart++;
      if (job_done) begin
        n_done++;
        done_cyc = cyc;
        chk("res_sb_avail", 64'(exp_tot_q.size() > 0), 64'd1);
        if (exp_tot_q.size() > 0) begin
          chk("total", total_counter, exp_tot_q.pop_front());
          chk("batches_done", 64'(batches_done), exp_bd_q.pop_front());
          chk("saturated", 64'(saturated), 64'(exp_sat_q.pop_front()));
        end
      end
    end
  end

  task automatic set_cores(input int d0, input int dstep, input bit pulse);
    for (int i = 0; i < NC; i++) dly[i] = d0 + dstep * i;
    pulse_mode = pulse;
  endtask

  task automatic push_exp(input logic [63:0] b, input logic [63:0] s, input logic [31:0] n);
    logic [64:0] acc;
    logic [63:0] v;
    logic        sat;
    acc = '0;
    sat = 1'b0;
    for (int bi = 0; bi < int'(n); bi++)
      for (int i = 0; i < NC; i++) begin
        v = b + 64'(bi * NC + i) * s;
        exp_seed_q.push_back((v == 64'd0) ? 64'd1 : v);
        acc = {1'b0, acc[63:0]} + {1'b0, cnt_val[i]};
        if (acc[64]) begin
          acc = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
          sat = 1'b1;
        end
      end
    exp_tot_q.push_back(acc[63:0]);
    exp_bd_q.push_back(64'(n));
    exp_sat_q.push_back(sat);
  endtask

  task automatic start_job(input logic [63:0] b, input logic [63:0] s, input logic [31:0] n);
    @(negedge clk);
    seed_base = b; seed_stride = s; job_batches = n; job_start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic run_job(input logic [63:0] b, input logic [63:0] s, input logic [31:0] n);
    int d0;
    int k;
    d0 = n_done;
    push_exp(b, s, n);
    start_job(b, s, n);
    k = 0;
    while (n_done == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("job_done_seen", 64'(n_done - d0), 64'd1);
  endtask

  task automatic flush_sb();
    exp_seed_q.delete();
    exp_tot_q.delete();
    exp_bd_q.delete();
    exp_sat_q.delete();
  endtask

  initial begin
    int s0, r0, d0, k;
    for (int i = 0; i < NC; i++) begin cnt_val[i] = '0; dly[i] = 1; end
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_total", total_counter, 64'd0);
    chk("rst_batches", 64'(batches_done), 64'd0);
    chk("rst_sat", 64'(saturated), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_restart", 64'(core_restart), 64'd0);
    chk("rst_done", 64'(job_done), 64'd0);
    chk("rst_seed_zero", 64'(|core_seed), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single batch, level done after 20 cycles
    for (int i = 0; i < NC; i++) cnt_val[i] = 64'(10 * (i + 1));
    set_cores(20, 0, 1'b0);
    s0 = n_start; r0 = n_restart;
    run_job(64'd1, 64'd1, 32'd1);
    chk("t1_start_lat", 64'(last_start_cyc - t_start), 64'd2);
    chk("t1_done_lat", 64'(done_cyc - last_done_cyc), 64'd7);
    chk("t1_starts", 64'(n_start - s0), 64'd1);
    chk("t1_restarts", 64'(n_restart - r0), 64'd0);
    @(negedge clk);
    chk("t1_idle", 64'(busy), 64'd0);

    // Three batches, stride 2
    for (int i = 0; i < NC; i++) cnt_val[i] = 64'd5;
    set_cores(12, 0, 1'b0);
    s0 = n_start; r0 = n_restart;
    run_job(64'd1, 64'd2, 32'd3);
    chk("t2_starts", 64'(n_start - s0), 64'd3);
    chk("t2_restarts", 64'(n_restart - r0), 64'd2);
    chk("t2_done_lat", 64'(done_cyc - last_done_cyc), 64'd7);

    // Staggered single-cycle done pulses
    for (int i = 0; i < NC; i++) cnt_val[i] = 64'(7 + 4 * i);
    set_cores(8, 5, 1'b1);
    run_job(64'd100, 64'd3, 32'd1);
    chk("t3_last_pulse", 64'(last_done_cyc - last_start_cyc), 64'd33);
    chk("t3_done_lat", 64'(done_cyc - last_done_cyc), 64'd7);

    // Saturation
    for (int i = 0; i < NC; i++) cnt_val[i] = '0;
    cnt_val[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    cnt_val[1] = 64'h20;
    set_cores(5, 1, 1'b0);
    run_job(64'd7, 64'd1, 32'd1);
    repeat (5) @(negedge clk);
    chk("t4_sat_hold", 64'(saturated), 64'd1);
    chk("t4_total_hold", total_counter, 64'hFFFF_FFFF_FFFF_FFFF);

    // Zero batches: immediate completion, clears sticky saturation
    s0 = n_start;
    run_job(64'd5, 64'd5, 32'd0);
    chk("t0_done_lat", 64'(done_cyc - t_start), 64'd1);
    chk("t0_no_start", 64'(n_start - s0), 64'd0);

    // Seed guard and zero stride
    for (int i = 0; i < NC; i++) cnt_val[i] = 64'd1;
    set_cores(4, 0, 1'b1);
    run_job(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd1);
    chk("t5_seed1_hold", core_seed[64 +: 64], 64'd1);
    chk("t5_seed2_hold", core_seed[128 +: 64], 64'd1);
    run_job(64'd0, 64'd0, 32'd1);

    // Abort during RUN of batch 2 of 4, with an ignored job_start mid-job
    for (int i = 0; i < NC; i++) cnt_val[i] = 64'd3;
    set_cores(10, 0, 1'b0);
    s0 = n_start; d0 = n_done;
    push_exp(64'd50, 64'd1, 32'd4);
    start_job(64'd50, 64'd1, 32'd4);
    repeat (3) @(negedge clk);
    seed_base = 64'd999; seed_stride = 64'd7; job_batches = 32'd1; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    k = 0;
    while (n_start - s0 < 2 && k < 500) begin @(negedge clk); k++; end
    chk("t6_second_start", 64'(n_start - s0), 64'd2);
    repeat (3) @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    chk("t6_restart", 64'(core_restart), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_no_done", 64'(job_done), 64'd0);
    chk("t6_batches", 64'(batches_done), 64'd1);
    chk("t6_total", total_counter, 64'd18);
    @(negedge clk);
    chk("t6_restart_1cyc", 64'(core_restart), 64'd0);
    repeat (20) @(negedge clk);
    chk("t6_no_done_late", 64'(n_done - d0), 64'd0);
    chk("t6_seeds_left", 64'(exp_seed_q.size()), 64'd12);
    flush_sb();

    // Abort and start together in IDLE: abort wins
    seed_base = 64'd1; seed_stride = 64'd1; job_batches = 32'd1;
    job_start = 1'b1; job_abort = 1'b1;
    @(negedge clk);
    job_start = 1'b0; job_abort = 1'b0;
    chk("t7_not_busy", 64'(busy), 64'd0);
    chk("t7_no_restart", 64'(core_restart), 64'd0);

    // Reset mid-job: no restart pulse
    push_exp(64'd1, 64'd1, 32'd2);
    start_job(64'd1, 64'd1, 32'd2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_rst_busy", 64'(busy), 64'd0);
    chk("t8_rst_restart", 64'(core_restart), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_post_restart", 64'(core_restart), 64'd0);
    flush_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
